ifetch_stage: RTL

Instruction fetch stage that sits directly upstream of the immediate sign-extension units. It holds the program counter and fetches 32-bit instructions over a req/ready handshake with instruction memory. It latches each word into an instruction register and presents the decoded fields to decode, including the raw 16-bit immediate and the 26-bit jump target that the sign extenders consume. Redirects from the branch unit and back-pressure from downstream are handled here.

---
 rtl/isa_pkg.sv | 42 ++++
 rtl/ifetch_stage_if.sv | 22 ++
 rtl/ifetch_stage_fsm.sv | 72 +++++++
 rtl/ifetch_stage.sv | 96 +++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA constants for the fetch stage: instruction field positions,
// fetch FSM states and the datapath select encodings driven by the FSM.
package isa_pkg;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RS_MSB     = 25;
  localparam int RS_LSB     = 21;
  localparam int RT_MSB     = 20;
  localparam int RT_LSB     = 16;
  localparam int SHAMT_MSB  = 15;
  localparam int SHAMT_LSB  = 11;
  localparam int FUNC_MSB   = 10;
  localparam int FUNC_LSB   = 6;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int TARGET_MSB = 25;
  localparam int TARGET_LSB = 0;

  localparam logic [31:0] PC_STEP_DEF  = 32'd4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  // Next-value selects for the pc and fetch_addr registers.
  typedef enum logic [1:0] {
    PC_KEEP  = 2'd0,
    PC_SEQ   = 2'd1,
    PC_REDIR = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    FA_KEEP  = 2'd0,
    FA_PC    = 2'd1,
    FA_REDIR = 2'd2
  } fa_sel_e;

endpackage

// File: rtl/ifetch_stage_if.sv
// Instruction-memory request/ready handshake between the fetch stage
// (master) and instruction memory (slave).
interface ifetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rdata
  );
endinterface

// File: rtl/ifetch_stage_fsm.sv
// Fetch control FSM: FETCH issues a request, HOLD presents the instruction,
// DROP finishes a handshake whose data was invalidated by a redirect.
module ifetch_fsm
  import isa_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    imem_ready,
  input  logic    stall,
  input  logic    redirect,
  output logic    req,
  output logic    capture,
  output logic    clr_valid,
  output pc_sel_e pc_sel,
  output fa_sel_e fa_sel
);

  fetch_state_e state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    req       = 1'b0;
    capture   = 1'b0;
    clr_valid = 1'b0;
    pc_sel    = PC_KEEP;
    fa_sel    = FA_KEEP;
    case (state_q)
      FETCH: begin
        req = 1'b1;
        if (imem_ready && redirect) begin
          pc_sel = PC_REDIR;
          fa_sel = FA_REDIR;
        end else if (imem_ready) begin
          capture = 1'b1;
          pc_sel  = PC_SEQ;
          state_d = HOLD;
        end else if (redirect) begin
          // Address already on the bus must stay put until memory answers.
          pc_sel  = PC_REDIR;
          state_d = DROP;
        end
      end
      HOLD: begin
        if (redirect) begin
          clr_valid = 1'b1;
          fa_sel    = FA_REDIR;
          state_d   = FETCH;
        end else if (!stall) begin
          clr_valid = 1'b1;
          fa_sel    = FA_PC;
          state_d   = FETCH;
        end
      end
      DROP: begin
        req = 1'b1;
        if (redirect) pc_sel = PC_REDIR;
        if (imem_ready) begin
          // A redirect on the same edge is newer than the saved pc.
          fa_sel  = redirect ? FA_REDIR : FA_PC;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch stage: PC, in-flight fetch address and instruction
// register, with decoded fields presented to decode as plain IR slices.
module ifetch_stage
  import isa_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEF
)(
  input  logic                  clk,
  input  logic                  rst_n,
  ifetch_stage_if.master        imem,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [31:0]           redirect_pc,
  output logic                  out_valid,
  output logic [31:0]           pc_out,
  output logic [31:0]           instr,
  output logic [5:0]            opcode,
  output logic [4:0]            rs,
  output logic [4:0]            rt,
  output logic [4:0]            shamt,
  output logic [4:0]            func,
  output logic [15:0]           imm16,
  output logic [25:0]           target26
);

  logic        req;
  logic        capture;
  logic        clr_valid;
  pc_sel_e     pc_sel;
  fa_sel_e     fa_sel;
  logic [31:0] pc;
  logic [31:0] fetch_addr;
  logic [31:0] ir;

  ifetch_fsm u_fsm (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_ready (imem.imem_ready),
    .stall      (stall),
    .redirect   (redirect),
    .req        (req),
    .capture    (capture),
    .clr_valid  (clr_valid),
    .pc_sel     (pc_sel),
    .fa_sel     (fa_sel)
  );

  // Request is state-derived; reset gating drops it the moment rst_n falls.
  assign imem.imem_req  = req & rst_n;
  assign imem.imem_addr = fetch_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      fetch_addr <= RESET_PC;
    end else begin
      case (pc_sel)
        PC_SEQ:   pc <= fetch_addr + PC_STEP;
        PC_REDIR: pc <= redirect_pc;
        default:  pc <= pc;
      endcase
      case (fa_sel)
        FA_PC:    fetch_addr <= pc;
        FA_REDIR: fetch_addr <= redirect_pc;
        default:  fetch_addr <= fetch_addr;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir        <= '0;
      pc_out    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (capture) begin
        ir        <= imem.imem_rdata;
        pc_out    <= fetch_addr;
        out_valid <= 1'b1;
      end else if (clr_valid) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign instr    = ir;
  assign opcode   = ir[OPCODE_MSB:OPCODE_LSB];
  assign rs       = ir[RS_MSB:RS_LSB];
  assign rt       = ir[RT_MSB:RT_LSB];
  assign shamt    = ir[SHAMT_MSB:SHAMT_LSB];
  assign func     = ir[FUNC_MSB:FUNC_LSB];
  assign imm16    = ir[IMM_MSB:IMM_LSB];
  assign target26 = ir[TARGET_MSB:TARGET_LSB];

endmodule
